// File: rtl/button_input_port.sv
`default_nettype none
// ============================================================================
//  Module      : button_input_port
//  Description : Memory-mapped, debounced input port for push-buttons and
//                slide switches. Raw pins are synchronised through two flops
//                and then debounced per bit. Rising edges of the debounced
//                level are captured in sticky flags. A level interrupt is
//                raised from the flags that are enabled in a mask register.
//
//  Ports       : sysClk - system clock, rising edge active
//                sysRes - synchronous active-high reset
//                pins   - raw asynchronous input levels [WIDTH]
//                a      - byte address; a[3:2] selects the register
//                we     - write strobe
//                wd     - write data [32]
//                rd     - combinational read data [32]
//                irq    - interrupt request, |(edges & mask)
//
//  Registers   : 0 STATE (RO), 1 EDGES (R/W1C), 2 MASK (R/W), 3 unmapped
//  Revision    : 1.0 - initial release
// ============================================================================
module button_input_port #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             sysClk,
    input  logic             sysRes,
    input  logic [WIDTH-1:0] pins,
    input  logic [3:0]       a,
    input  logic             we,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic             irq
);

    localparam int            CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] C_REG_STATE = 2'd0;
    localparam logic [1:0] C_REG_EDGES = 2'd1;
    localparam logic [1:0] C_REG_MASK  = 2'd2;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] edges_q, edges_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;

    // Address bits [1:0] and the upper write-data bits are intentionally
    // unused for narrow ports.
    logic w_unused;
    assign w_unused = &{1'b0, a[1:0], wd};

    // ------------------------------------------------------------------
    // Debounce: a bit is accepted only after sync2 has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive cycles. Any cycle where
    // it agrees again drops the count back to zero.
    // ------------------------------------------------------------------
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == C_CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = stable_d & ~stable_q;

    // A rising edge in the same cycle as a write-1-to-clear keeps the flag set.
    assign w_clr   = (we && (a[3:2] == C_REG_EDGES)) ? wd[WIDTH-1:0] : '0;
    assign edges_d = (edges_q & ~w_clr) | w_rise;
    assign mask_d  = (we && (a[3:2] == C_REG_MASK)) ? wd[WIDTH-1:0] : mask_q;

    always_ff @(posedge sysClk) begin
        if (sysRes) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            edges_q  <= '0;
            mask_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= pins;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            edges_q  <= edges_d;
            mask_q   <= mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux; bits above WIDTH read as zero.
    // ------------------------------------------------------------------
    always_comb begin
        rd = '0;
        case (a[3:2])
            C_REG_STATE: rd[WIDTH-1:0] = stable_q;
            C_REG_EDGES: rd[WIDTH-1:0] = edges_q;
            C_REG_MASK:  rd[WIDTH-1:0] = mask_q;
            default:     rd = '0;
        endcase
    end

    assign irq = |(edges_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_button_input_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_input_port
//  Description : Directed self-checking bench for button_input_port with
//                WIDTH=16, DEBOUNCE_CYCLES=4 (accept at the 6th edge after a
//                pin change).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_input_port;

    localparam int WIDTH = 16;
    localparam int DEB   = 4;

    localparam logic [3:0] A_STATE = 4'h0;
    localparam logic [3:0] A_EDGES = 4'h4;
    localparam logic [3:0] A_MASK  = 4'h8;
    localparam logic [3:0] A_NONE  = 4'hC;

    logic             sysClk = 1'b0;
    logic             sysRes = 1'b1;
    logic [WIDTH-1:0] pins   = '0;
    logic [3:0]       a      = '0;
    logic             we     = 1'b0;
    logic [31:0]      wd     = '0;
    logic [31:0]      rd;
    logic             irq;

    int total = 0;
    int bad   = 0;

    button_input_port #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .sysClk (sysClk),
        .sysRes (sysRes),
        .pins   (pins),
        .a      (a),
        .we     (we),
        .wd     (wd),
        .rd     (rd),
        .irq    (irq)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // The write lands on the next rising edge.
    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        tick(1);
        we = 1'b0;
        wd = '0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        pins   = 16'hFFFF;
        sysRes = 1'b1;
        tick(2);
        sysRes = 1'b0;
        rd_chk("rst_state", A_STATE, 32'h0);
        rd_chk("rst_edges", A_EDGES, 32'h0);
        rd_chk("rst_mask",  A_MASK,  32'h0);
        rd_chk("rst_none",  A_NONE,  32'h0);
        irq_chk("rst_irq", 1'b0);
        tick(DEB + 1);
        rd_chk("rst_state_e5", A_STATE, 32'h0);
        tick(1);
        rd_chk("rst_state_e6", A_STATE, 32'h0000FFFF);
        rd_chk("rst_edges_e6", A_EDGES, 32'h0000FFFF);
        pins = '0;
        tick(DEB + 2);
        rd_chk("rst_fall", A_STATE, 32'h0);
        wr(A_EDGES, 32'hFFFF_FFFF);
        rd_chk("rst_clr", A_EDGES, 32'h0);

        // ---------------- debounce latency ----------------
        wr(A_MASK, 32'h1);
        pins = 16'h0001;
        tick(5);
        rd_chk("deb_state_e5", A_STATE, 32'h0);
        irq_chk("deb_irq_e5", 1'b0);
        tick(1);
        rd_chk("deb_state_e6", A_STATE, 32'h1);
        rd_chk("deb_edges_e6", A_EDGES, 32'h1);
        irq_chk("deb_irq_e6", 1'b1);
        pins = 16'h0000;
        tick(5);
        rd_chk("deb_fall_e5", A_STATE, 32'h1);
        tick(1);
        rd_chk("deb_fall_e6", A_STATE, 32'h0);
        rd_chk("deb_fall_edges", A_EDGES, 32'h1);

        // ---------------- glitch rejection ----------------
        wr(A_EDGES, 32'h1);
        wr(A_MASK, 32'h0);
        for (int k = 0; k < 16; k++) begin
            pins = (k < 3 || (k >= 4 && k < 7)) ? 16'h0008 : 16'h0000;
            tick(1);
            rd_chk("glitch_state", A_STATE, 32'h0);
            rd_chk("glitch_edges", A_EDGES, 32'h0);
        end

        // ---------------- W1C and masking ----------------
        pins = 16'h0005;
        tick(DEB + 2);
        pins = 16'h0000;
        tick(DEB + 2);
        wr(A_MASK, 32'h4);
        rd_chk("w1c_setup", A_EDGES, 32'h5);
        irq_chk("w1c_irq_setup", 1'b1);
        wr(A_EDGES, 32'h4);
        rd_chk("w1c_edges", A_EDGES, 32'h1);
        irq_chk("w1c_irq_off", 1'b0);
        wr(A_MASK, 32'hFFFF);
        rd_chk("mask_rd", A_MASK, 32'hFFFF);
        irq_chk("mask_irq_on", 1'b1);
        wr(A_MASK, 32'hABCD_1234);
        rd_chk("mask_trunc", A_MASK, 32'h1234);
        wr(A_MASK, 32'hFFFF);
        wr(A_STATE, 32'hFFFF);
        rd_chk("state_ro", A_STATE, 32'h0);
        rd_chk("state_ro_edges", A_EDGES, 32'h1);
        wr(A_NONE, 32'hFFFF);
        rd_chk("none_rd", A_NONE, 32'h0);
        rd_chk("none_mask", A_MASK, 32'hFFFF);

        // ---------------- set wins over W1C ----------------
        wr(A_EDGES, 32'hFFFF);
        rd_chk("sw_clr", A_EDGES, 32'h0);
        pins = 16'h0002;
        tick(5);
        rd_chk("sw_pre", A_EDGES, 32'h0);
        wr(A_EDGES, 32'h2);           // lands on edge 6, when stable[1] rises
        rd_chk("sw_edges", A_EDGES, 32'h2);
        rd_chk("sw_state", A_STATE, 32'h2);
        pins = 16'h0000;
        tick(DEB + 2);
        wr(A_EDGES, 32'hFFFF);
        rd_chk("sw_done", A_EDGES, 32'h0);

        // ---------------- mid-count reset ----------------
        pins = 16'h0020;
        tick(3);
        sysRes = 1'b1;
        tick(1);                      // reset on edge 4
        sysRes = 1'b0;
        rd_chk("mr_mask", A_MASK, 32'h0);
        rd_chk("mr_state0", A_STATE, 32'h0);
        tick(5);
        rd_chk("mr_state5", A_STATE, 32'h0);
        tick(1);
        rd_chk("mr_state6", A_STATE, 32'h20);
        rd_chk("mr_edges6", A_EDGES, 32'h20);
        irq_chk("mr_irq_masked", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_input_port.md
# button_input_port

Memory-mapped, debounced input port for the board's push-buttons and slide switches. It is the input counterpart of the LED debug output path: asynchronous pins are synchronised and debounced, and rising edges are captured in sticky flags. A level-sensitive interrupt request is raised from those flags. The CPU reads the port through a small word-addressed register window on the data bus, decoded by the top-level address map.

## Interface

Parameters:
- WIDTH, 16, number of input pins (1..32)
- DEBOUNCE_CYCLES, 50000, cycles a synchronised pin must hold a new level before it is accepted (>= 2)

Ports:
- sysClk  input  1  system clock; all state updates on its rising edge
- sysRes  input  1  reset, synchronous, active-high
- pins  input  WIDTH  raw asynchronous button/switch levels
- a  input  4  byte address within the window; a[3:2] selects the register, a[1:0] ignored
- we  input  1  write strobe, sampled on the rising edge of sysClk
- wd  input  32  write data
- rd  output  32  read data, combinational from a
- irq  output  1  interrupt request, combinational

## Operation

- Per-bit pipeline: sync1 <= pins, sync2 <= sync1, then debounce on sync2.
- Each bit has a debounce counter, ceil(log2(DEBOUNCE_CYCLES)) bits wide, and a stable level.
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Any single cycle where sync2 returns to the stable level restarts the count from 0. This filters glitches.
- Edge capture: the cycle in which stable goes 0->1 sets edges[i] (sticky). Falling edges set nothing.
- Register map (a[3:2]):
  - 0: STATE, read-only. rd = stable, zero-extended. Writes are ignored.
  - 1: EDGES, read / write-1-to-clear. rd = edges. A write clears each edges[i] where wd[i]=1.
  - 2: MASK, read/write. rd = mask. A write sets mask <= wd[WIDTH-1:0].
  - 3: unmapped. rd = 0 and writes are ignored.
- rd bits above WIDTH always read 0.
- Reads have no side effects.
- irq = |(edges & mask).
- Simultaneous W1C and a new rising edge on the same bit: the set wins, and edges[i] stays 1.

## Timing

- Reset (sysRes=1 at a rising edge) clears all state in the same edge:
  - sync1, sync2, stable, all counters: 0
  - edges: 0, mask: 0
  - resulting outputs: rd = 0 for every address, irq = 0
- Reset asserted mid-count abandons the count. A pin held high through reset is re-debounced from scratch after release and then produces a rising edge.
- Latency: a pin changes and is held. Take edge 1 as the first rising edge sampling the new level. stable and the corresponding edges bit update at edge DEBOUNCE_CYCLES+2. irq follows combinationally in the same cycle.
- A pulse on pins shorter than DEBOUNCE_CYCLES cycles (after synchronisation) never changes stable.
- Register writes take effect at the rising edge where we=1; rd reflects the new value in the following cycle.
- The counter never wraps: it saturates into the accept step at DEBOUNCE_CYCLES-1.

## Test plan

Run with WIDTH=16 and DEBOUNCE_CYCLES=4.

- **Reset values:** hold sysRes for 2 cycles with pins=0xFFFF, then release. Immediately after release, rd=0 at a=0x0, 0x4, 0x8, 0xC and irq=0. STATE reads 0xFFFF exactly 6 edges after release.
- **Debounce latency:** with mask=0x0001, raise pins[0] and hold. STATE bit 0 and EDGES bit 0 go to 1 at edge 6, and irq=1 in that cycle. Lower pins[0] and hold: STATE bit 0 goes to 0 at edge 6, and EDGES stays 0x0001.
- **Glitch rejection:** apply pins[3] high for 3 cycles, low for 1, high for 3, then low. STATE and EDGES remain 0 throughout.
- **W1C and masking:**
  - Setup: edges=0x0005, mask=0x0004, giving irq=1.
  - Write 0x0004 to EDGES: reads back 0x0001 and irq=0.
  - Write 0xFFFF to MASK: reads back 0xFFFF and irq=1.
- **Set-wins collision:** time a write of 0x0002 to EDGES on the same edge that stable[1] rises. EDGES reads 0x0002 afterwards.
- **Mid-count reset:** raise pins[5], and assert sysRes for 1 cycle at edge 4. STATE bit 5 stays 0 until 6 edges after release, then reads 1 with EDGES bit 5 set.
